// File: rtl/ex_stage_if.sv
// ex_stage_if: upstream handshake/payload, ALU drive/response and downstream handshake/payload of ex_stage.
// master = surrounding environment (producer, ALU, consumer); slave = the ex_stage itself.
interface ex_stage_if #(
    parameter int W  = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [RW-1:0] in_rd;
    logic          in_we;
    logic          in_setf;
    logic          in_use_c;
    logic [RW-1:0] in_rs1;
    logic [RW-1:0] in_rs2;

    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_op;
    logic          alu_cin;
    logic [W-1:0]  alu_result;
    logic          alu_z;
    logic          alu_c;
    logic          alu_v;
    logic          alu_n;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [RW-1:0] out_rd;
    logic          out_we;
    logic [3:0]    flags;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, in_we, in_setf, in_use_c, in_rs1, in_rs2,
        input  in_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_result, alu_z, alu_c, alu_v, alu_n,
        input  out_valid, out_result, out_rd, out_we, flags,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, in_we, in_setf, in_use_c, in_rs1, in_rs2,
        output in_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_result, alu_z, alu_c, alu_v, alu_n,
        output out_valid, out_result, out_rd, out_we, flags,
        input  out_ready
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: two-register execute stage (S1 operands, S2 result) wrapped around an external combinational ALU.
// Optional feature: define EX_STAGE_FWD_EN to bypass the S2 result onto the ALU operands on a source-index match.
module ex_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    localparam int FLAG_C = 1;

    logic          s1_valid_r;
    logic [3:0]    s1_op_r;
    logic [W-1:0]  s1_a_r;
    logic [W-1:0]  s1_b_r;
    logic [RW-1:0] s1_rd_r;
    logic          s1_we_r;
    logic          s1_setf_r;
    logic          s1_use_c_r;

    logic          s2_valid_r;
    logic [W-1:0]  s2_result_r;
    logic [RW-1:0] s2_rd_r;
    logic          s2_we_r;
    logic [3:0]    flags_r;

    logic          s2_free_s;
    logic          s1_adv_s;
    logic          in_ready_s;
    logic          in_acc_s;
    logic [W-1:0]  opa_s;
    logic [W-1:0]  opb_s;

    // Stage handshake; in_ready depends only on occupancy and out_ready, never on in_valid.
    always_comb begin
        s2_free_s  = !s2_valid_r || bus.out_ready;
        s1_adv_s   = s1_valid_r && s2_free_s;
        in_ready_s = !s1_valid_r || s1_adv_s;
        in_acc_s   = bus.in_valid && in_ready_s;
    end

`ifdef EX_STAGE_FWD_EN
    logic [RW-1:0] s1_rs1_r;
    logic [RW-1:0] s1_rs2_r;
    logic          fwd_ok_s;

    // Operand select: the producer sitting in S2 overrides a stale register value.
    always_comb begin
        fwd_ok_s = s2_valid_r && s2_we_r && (s2_rd_r != {RW{1'b0}});
        if (fwd_ok_s && (s1_rs1_r == s2_rd_r)) begin
            opa_s = s2_result_r;
        end else begin
            opa_s = s1_a_r;
        end
        if (fwd_ok_s && (s1_rs2_r == s2_rd_r)) begin
            opb_s = s2_result_r;
        end else begin
            opb_s = s1_b_r;
        end
    end

    // Source indices travel with the operands through S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rs1_r <= {RW{1'b0}};
            s1_rs2_r <= {RW{1'b0}};
        end else if (in_acc_s) begin
            s1_rs1_r <= bus.in_rs1;
            s1_rs2_r <= bus.in_rs2;
        end
    end
`else
    logic unused_rs_s;
    assign unused_rs_s = ^{bus.in_rs1, bus.in_rs2};

    // Operands come straight from S1; source indices have no effect in this build.
    always_comb begin
        opa_s = s1_a_r;
        opb_s = s1_b_r;
    end
`endif

    // S1: operand register, refilled in the same cycle it advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 4'b0000;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_rd_r    <= {RW{1'b0}};
            s1_we_r    <= 1'b0;
            s1_setf_r  <= 1'b0;
            s1_use_c_r <= 1'b0;
        end else if (in_acc_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= bus.in_op;
            s1_a_r     <= bus.in_a;
            s1_b_r     <= bus.in_b;
            s1_rd_r    <= bus.in_rd;
            s1_we_r    <= bus.in_we;
            s1_setf_r  <= bus.in_setf;
            s1_use_c_r <= bus.in_use_c;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2: result register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {W{1'b0}};
            s2_rd_r     <= {RW{1'b0}};
            s2_we_r     <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r  <= 1'b1;
            s2_result_r <= bus.alu_result;
            s2_rd_r     <= s1_rd_r;
            s2_we_r     <= s1_we_r;
        end else if (s2_valid_r && bus.out_ready) begin
            s2_valid_r  <= 1'b0;
        end
    end

    // Flags commit when the setting op leaves S1, so the next op in S1 sees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (s1_adv_s && s1_setf_r) begin
            flags_r <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.alu_a      = opa_s;
    assign bus.alu_b      = opb_s;
    assign bus.alu_op     = s1_op_r;
    assign bus.alu_cin    = s1_use_c_r & flags_r[FLAG_C];
    assign bus.out_valid  = s2_valid_r;
    assign bus.out_result = s2_result_r;
    assign bus.out_rd     = s2_rd_r;
    assign bus.out_we     = s2_we_r;
    assign bus.flags      = flags_r;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with an attached ALU and an in-order transaction model.
module tb_ex_stage;
    localparam int W  = 32;
    localparam int RW = 5;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if #(.W(W), .RW(RW)) bus ();
    ex_stage #(.W(W), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {N,Z,C,V,result}; carry on SUB means "no borrow".
    function automatic logic [W+3:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c, v;
        wide = {(W+1){1'b0}}; r = {W{1'b0}}; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                r = wide[W-1:0]; c = wide[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                r = wide[W-1:0]; c = wide[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
        return {r[W-1], (r == {W{1'b0}}), c, v, r};
    endfunction

    logic [W+3:0] alu_out;
    always_comb begin
        alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
        bus.alu_result = alu_out[W-1:0];
        bus.alu_n = alu_out[W+3];
        bus.alu_z = alu_out[W+2];
        bus.alu_c = alu_out[W+1];
        bus.alu_v = alu_out[W];
    end

    typedef struct packed {
        logic [W-1:0]  res;
        logic [RW-1:0] rd;
        logic          we;
        logic [3:0]    fl;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  deliv_res[$];
    int            acc_cycs[$];
    int            del_cycs[$];
    logic [3:0]    m_flags = 4'b0000;
    logic [W-1:0]  prev_res = {W{1'b0}};
    logic [RW-1:0] prev_rd = {RW{1'b0}};
    logic          prev_we = 1'b0;
    int            prev_acc_cyc = -10;
    logic [W-1:0]  ma, mb;
    logic [W+3:0]  mr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Model: each accepted op executes in program order against the flags of all older ops.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            ma = bus.in_a;
            mb = bus.in_b;
`ifdef EX_STAGE_FWD_EN
            if (prev_acc_cyc == cyc - 1 && prev_we && prev_rd != {RW{1'b0}}) begin
                if (bus.in_rs1 == prev_rd) ma = prev_res;
                if (bus.in_rs2 == prev_rd) mb = prev_res;
            end
`endif
            mr = alu_fn(bus.in_op, ma, mb, bus.in_use_c & m_flags[1]);
            if (bus.in_setf) m_flags = mr[W+3:W];
            exp_q.push_back('{res: mr[W-1:0], rd: bus.in_rd, we: bus.in_we, fl: m_flags});
            prev_res = mr[W-1:0];
            prev_rd = bus.in_rd;
            prev_we = bus.in_we;
            prev_acc_cyc = cyc;
            acc_cycs.push_back(cyc);
        end
    end

    // Compare: whatever S2 presents must be the oldest outstanding op, with flags as of that op.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {32'd0, bus.out_result}, 64'hDEAD);
            end else begin
                chk("out_payload", {22'd0, bus.out_result, bus.out_rd, bus.out_we, bus.flags},
                    {22'd0, exp_q[0].res, exp_q[0].rd, exp_q[0].we, exp_q[0].fl});
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    deliv_res.push_back(bus.out_result);
                    del_cycs.push_back(cyc);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rd, input logic we, input logic setf,
                         input logic usec, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_rd = rd;
        bus.in_we = we; bus.in_setf = setf; bus.in_use_c = usec; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] rd, input logic we, input logic setf,
                        input logic usec, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        logic got;
        int n;
        drive(op, a, b, rd, we, setf, usec, rs1, rs2);
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", {63'd0, (n >= 100)}, 64'd0);
    endtask

    logic [3:0]   v_op  [8] = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_ADD, OP_SUB, OP_ADD, OP_SUB};
    logic [W-1:0] v_a   [8] = '{32'd3, 32'd10, 32'hF0F0F0F0, 32'hAAAAAAAA, 32'h7FFFFFFF, 32'd5, 32'd2, 32'd0};
    logic [W-1:0] v_b   [8] = '{32'd4, 32'd3, 32'hFF00FF00, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd3, 32'd1};
    logic         v_setf[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         v_usec[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] v_exp [8] = '{32'd7, 32'd7, 32'hF000F000, 32'h55555555, 32'h80000000, 32'd0, 32'd6, 32'hFFFFFFFF};

    initial begin
        int n_acc, base, k;
        logic got;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_out_payload", {26'd0, bus.out_result, bus.out_rd, bus.out_we}, 64'd0);
        chk("reset_flags", {60'd0, bus.flags}, 64'd0);
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones plus one sets Z and C; the next op picks up C as carry-in.
        send(OP_ADD, 32'hFFFFFFFF, 32'd1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        send(OP_ADD, 32'd1, 32'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_result", {32'd0, bus.out_result}, 64'd0);
        chk("wrap_flags", {60'd0, bus.flags}, 64'h6);
        chk("carry_in_seen", {63'd0, bus.alu_cin}, 64'd1);
        wait_drain();
        chk("carry_in_result", {32'd0, deliv_res[$]}, 64'd3);

        // Dependent pair: op2 reads rd=3 right behind its producer.
        send(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        send(OP_ADD, 32'd0, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        bus.in_valid = 1'b0;
        wait_drain();
`ifdef EX_STAGE_FWD_EN
        chk("fwd_result", {32'd0, deliv_res[$]}, 64'd13);
`else
        chk("nofwd_result", {32'd0, deliv_res[$]}, 64'd1);
`endif

        // Eight back-to-back ops with the consumer always ready.
        acc_cycs.delete(); del_cycs.delete(); deliv_res.delete();
        for (int i = 0; i < 8; i++) begin
            send(v_op[i], v_a[i], v_b[i], RW'(i + 1), 1'b1, v_setf[i], v_usec[i], 5'd0, 5'd0);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        chk("burst_count", 64'(deliv_res.size()), 64'd8);
        for (int i = 0; i < 8 && i < deliv_res.size(); i++) begin
            chk($sformatf("burst_res%0d", i), {32'd0, deliv_res[i]}, {32'd0, v_exp[i]});
        end
        if (del_cycs.size() == 8 && acc_cycs.size() == 8) begin
            chk("burst_latency", 64'(del_cycs[0] - acc_cycs[0]), 64'd2);
            chk("burst_back_to_back", 64'(del_cycs[7] - del_cycs[0]), 64'd7);
        end else begin
            chk("burst_bookkeeping", 64'(del_cycs.size()), 64'd8);
        end
        chk("burst_flags", {60'd0, bus.flags}, 64'h8);

        // Consumer stalled for five cycles while the producer keeps offering.
        bus.out_ready = 1'b0;
        base = deliv_res.size();
        k = 0;
        n_acc = 0;
        drive(OP_ADD, 32'd100, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            if (got) n_acc++;
            @(posedge clk); #1;
            if (got) begin
                k++;
                drive(OP_ADD, 32'(100 + k), 32'd1, RW'(5 + k), 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            end
        end
        chk("stall_accepted", 64'(n_acc), 64'd2);
        chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("stall_held_result", {32'd0, bus.out_result}, 64'd101);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("stall_delivered", 64'(deliv_res.size() - base), 64'd2);
        if (deliv_res.size() >= base + 2) begin
            chk("stall_order0", {32'd0, deliv_res[base]}, 64'd101);
            chk("stall_order1", {32'd0, deliv_res[base + 1]}, 64'd102);
        end

        // Reset in the middle of a stalled stream, then one op after release.
        bus.out_ready = 1'b0;
        send(OP_ADD, 32'h7FFFFFFF, 32'd1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        send(OP_ADD, 32'd9, 32'd9, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midreset_flags", {60'd0, bus.flags}, 64'd0);
        chk("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        exp_q.delete(); acc_cycs.delete(); del_cycs.delete();
        m_flags = 4'b0000;
        prev_acc_cyc = -10;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(OP_ADD, 32'd20, 32'd22, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        bus.in_valid = 1'b0;
        wait_drain();
        if (del_cycs.size() == 1 && acc_cycs.size() == 1) begin
            chk("postreset_latency", 64'(del_cycs[0] - acc_cycs[0]), 64'd2);
        end else begin
            chk("postreset_count", 64'(del_cycs.size()), 64'd1);
        end
        chk("postreset_result", {32'd0, deliv_res[$]}, 64'd42);
        chk("postreset_flags", {60'd0, bus.flags}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
